// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory arbiter state encoding and the canonical NOP instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/mem_timeout_timer.sv
// Counts cycles while enabled and flags the last permitted cycle; TIMEOUT_CYCLES of 0 never expires.
module mem_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // expired marks the TIMEOUT_CYCLES-th enabled cycle, so the owner aborts on that cycle
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction at a
// time, and raises the pipeline-wide stall while either requester is waiting.
module unified_mem_arbiter
  import pipe_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] NOP_INSTR      = DATA_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_done_q, d_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              discard_q, discard_d;
  logic              busy;
  logic              expired;

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  mem_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign timeout_err = timeout_err_q;

  // A requester stops stalling in the very cycle its completion pulse is visible
  assign stall = (d_req && !d_done_q) || (if_req && !if_flush && !if_valid_q);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    if_rdata_d    = if_rdata_q;
    if_valid_d    = 1'b0;
    d_rdata_d     = d_rdata_q;
    d_done_d      = 1'b0;
    timeout_err_d = timeout_err_q;
    discard_d     = discard_q;

    case (state_q)
      IDLE: begin
        // Data side is the older instruction in the pipe, so it always wins
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_we ? d_be : 4'hF;
        end else if (if_req && !if_flush) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end
      end

      BUSY_I, BUSY_D: begin
        if (state_q == BUSY_I && if_flush) begin
          discard_d = 1'b1;
        end
        // A real response takes priority over a timeout landing in the same cycle
        if (mem_ready || expired) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_ready) begin
            timeout_err_d = 1'b1;
          end
          if (state_q == BUSY_D) begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            if_valid_d = !(discard_q || if_flush);
            if_rdata_d = mem_ready ? mem_rdata : NOP_INSTR;
          end
        end
      end

      RESP: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= 4'h0;
      if_rdata_q    <= '0;
      if_valid_q    <= 1'b0;
      d_rdata_q     <= '0;
      d_done_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      if_rdata_q    <= if_rdata_d;
      if_valid_q    <= if_valid_d;
      d_rdata_q     <= d_rdata_d;
      d_done_q      <= d_done_d;
      timeout_err_q <= timeout_err_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: both requesters and the memory are modelled at transaction level,
// every cycle's outputs are compared against that model, and directed scenarios pin it with literals.
module tb_unified_mem_arbiter;

  localparam int          T   = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_valid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_done;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_be = 4'h0;
  logic        stall, mem_req, mem_we, mem_ready = 1'b0, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dop_t;

  int testsRun = 0, testsFailed = 0, cyc = 0;
  bit randomMode = 0;

  // Scripted work for the requesters and per-transaction memory latencies
  dop_t        dQueue[$];
  logic [31:0] iQueue[$];
  int          delayQueue[$];
  int          flushAtK = -1;

  // Requester intent
  bit          dActive = 0, iActive = 0, prevDDone = 0, prevIValid = 0;
  dop_t        dOp = '0;
  logic [31:0] iAddr = '0;

  // The one transaction the memory is currently serving
  bit          tActive = 0, tFetch = 0, tDiscard = 0, timeoutSeen = 0;
  dop_t        tOp = '0;
  int          tGrant = 0, tEnd = -1, tDelay = 1;
  logic [31:0] tResult = '0;

  // modelMem follows what requesters asked for; physMem is what the memory sees on mem_*
  logic [31:0] modelMem [16];
  logic [31:0] physMem [16];

  int          dDoneCount, iValidCount, memReqCycles, stallCycles, firstPulse;
  int          lastDoneCycle, lastGrantCycle;
  logic [31:0] lastIfRdata, lastDRdata;

  function automatic logic [31:0] mergeBe(logic [31:0] oldW, logic [31:0] newW, logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
    return r;
  endfunction

  function automatic dop_t makeOp(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
    dop_t o;
    o.we = we; o.addr = addr; o.wdata = wdata; o.be = be;
    return o;
  endfunction

  function automatic dop_t randomOp();
    logic we;
    we = ($urandom_range(0, 2) == 0);
    return makeOp(we, $urandom() & 32'hFFFF_FFFC, $urandom(), we ? 4'($urandom_range(1, 15)) : 4'hF);
  endfunction

  function automatic int randomDelay();
    return ($urandom_range(0, 7) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkZero();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_d_done", d_done, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_stall", stall, 0);
  endtask

  task automatic resetCounters();
    dDoneCount = 0; iValidCount = 0; memReqCycles = 0; stallCycles = 0; firstPulse = 0;
    lastDoneCycle = 0; lastGrantCycle = 0; lastIfRdata = '0; lastDRdata = '0;
  endtask

  // One clock: requesters and memory react, then every output is compared with the model
  task automatic applyStimulus();
    int k, idx;
    bit busy, resp, flush, ready, expDDone, expIValid;
    @(posedge clk);
    #1;
    cyc++;
    if (prevDDone) dActive = 0;
    if (prevIValid) iActive = 0;
    prevDDone = 0; prevIValid = 0;
    if (!dActive) begin
      if (dQueue.size() > 0) begin dOp = dQueue.pop_front(); dActive = 1; end
      else if (randomMode && $urandom_range(0, 3) == 0) begin dOp = randomOp(); dActive = 1; end
    end
    if (!iActive) begin
      if (iQueue.size() > 0) begin iAddr = iQueue.pop_front(); iActive = 1; end
      else if (randomMode && $urandom_range(0, 2) == 0) begin iAddr = $urandom() & 32'hFFFF_FFFC; iActive = 1; end
    end

    if (tActive && tEnd >= 0 && cyc >= tEnd + 2) tActive = 0;
    busy = tActive && (tEnd < 0);
    resp = tActive && (tEnd >= 0) && (cyc == tEnd + 1);
    k    = cyc - tGrant;

    flush = 0;
    if (iActive && !resp) begin
      if (randomMode) flush = ($urandom_range(0, 9) == 0);
      else if (busy && tFetch && k == flushAtK) begin flush = 1; flushAtK = -1; end
    end
    ready = busy ? (k == tDelay) : (randomMode && $urandom_range(0, 7) == 0);

    d_req = dActive; d_we = dOp.we; d_addr = dOp.addr; d_wdata = dOp.wdata; d_be = dOp.be;
    if_req = iActive; if_addr = iAddr; if_flush = flush;
    mem_ready = ready;
    mem_rdata = (busy && ready) ? physMem[mem_addr[5:2]] : $urandom();
    if (mem_req && mem_we && mem_ready)
      physMem[mem_addr[5:2]] = mergeBe(physMem[mem_addr[5:2]], mem_wdata, mem_be);
    #1;

    expDDone  = resp && !tFetch;
    expIValid = resp && tFetch && !tDiscard;
    checkOutput("mem_req", mem_req, busy);
    checkOutput("d_done", d_done, expDDone);
    checkOutput("if_valid", if_valid, expIValid);
    checkOutput("stall", stall, (dActive && !expDDone) || (iActive && !flush && !expIValid));
    checkOutput("timeout_err", timeout_err, timeoutSeen);
    if (busy) begin
      checkOutput("mem_addr", mem_addr, tOp.addr);
      checkOutput("mem_we", mem_we, tOp.we);
      checkOutput("mem_be", mem_be, tOp.we ? tOp.be : 4'hF);
      if (tOp.we) checkOutput("mem_wdata", mem_wdata, tOp.wdata);
    end
    if (expDDone && !tOp.we) checkOutput("d_rdata", d_rdata, tResult);
    if (expIValid) checkOutput("if_rdata", if_rdata, tResult);

    if (d_done) begin dDoneCount++; lastDoneCycle = cyc; lastDRdata = d_rdata; end
    if (if_valid) begin iValidCount++; lastDoneCycle = cyc; lastIfRdata = if_rdata; end
    if (firstPulse == 0 && d_done) firstPulse = 1;
    else if (firstPulse == 0 && if_valid) firstPulse = 2;
    if (mem_req) memReqCycles++;
    if (stall) stallCycles++;

    if (busy) begin
      if (flush && tFetch) tDiscard = 1;
      idx = int'(tOp.addr[5:2]);
      if (ready) begin
        tEnd = cyc;
        if (tOp.we) modelMem[idx] = mergeBe(modelMem[idx], tOp.wdata, tOp.be);
        tResult = modelMem[idx];
      end else if (k == T) begin
        tEnd = cyc;
        timeoutSeen = 1;
        tResult = tFetch ? NOP : 32'h0;
      end
    end
    if (resp) begin prevDDone = expDDone; prevIValid = expIValid; end
    if (!tActive) begin
      if (dActive) begin
        tActive = 1; tFetch = 0; tOp = dOp;
      end else if (iActive && !flush) begin
        tActive = 1; tFetch = 1; tOp = makeOp(1'b0, iAddr, 32'h0, 4'hF);
      end
      if (tActive) begin
        tGrant = cyc; tEnd = -1; tDiscard = 0; lastGrantCycle = cyc;
        if (delayQueue.size() > 0) tDelay = delayQueue.pop_front();
        else tDelay = randomMode ? randomDelay() : 1;
      end
    end
    if (flush && randomMode) iAddr = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic runUntilIdle(int maxCycles);
    int n;
    bit drained;
    n = 0;
    do begin
      applyStimulus();
      n++;
      drained = !dActive && !iActive && !tActive && dQueue.size() == 0 && iQueue.size() == 0;
    end while (!drained && n < maxCycles);
    checkOutput("drain_within_budget", drained, 1);
  endtask

  // Reset for one edge; lateReady then presents a stray memory response in the following cycle
  task automatic applyReset(bit lateReady);
    rst_n = 0; d_req = 0; if_req = 0; if_flush = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1;
    tActive = 0; dActive = 0; iActive = 0; prevDDone = 0; prevIValid = 0; timeoutSeen = 0;
    dQueue.delete(); iQueue.delete(); delayQueue.delete(); flushAtK = -1;
    mem_ready = lateReady;
    #1;
    checkZero();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      modelMem[i] = $urandom();
      physMem[i]  = modelMem[i];
    end
    modelMem[0] = 32'hDEADBEEF; physMem[0] = 32'hDEADBEEF;
    modelMem[1] = 32'hAAAAAAAA; physMem[1] = 32'hAAAAAAAA;
    resetCounters();
    @(posedge clk);
    applyReset(1'b0);

    // Single load, memory answers on the third request cycle
    resetCounters();
    dQueue.push_back(makeOp(1'b0, 32'h100, 32'h0, 4'hF));
    delayQueue.push_back(3);
    runUntilIdle(40);
    checkOutput("t1_done_latency", lastDoneCycle - lastGrantCycle, 4);
    checkOutput("t1_rdata", lastDRdata, 32'hDEADBEEF);
    checkOutput("t1_stall_cycles", stallCycles, 4);
    checkOutput("t1_done_count", dDoneCount, 1);

    // Contention: data first, then the fetch, one pulse each
    resetCounters();
    dQueue.push_back(makeOp(1'b0, 32'h104, 32'h0, 4'hF));
    iQueue.push_back(32'h208);
    delayQueue.push_back(2);
    delayQueue.push_back(1);
    runUntilIdle(40);
    checkOutput("t2_d_done_count", dDoneCount, 1);
    checkOutput("t2_if_valid_count", iValidCount, 1);
    checkOutput("t2_data_first", firstPulse, 1);

    // Flush while the fetch is in flight: discarded, then refetched normally
    resetCounters();
    iQueue.push_back(32'h200);
    delayQueue.push_back(4);
    delayQueue.push_back(2);
    flushAtK = 2;
    runUntilIdle(40);
    checkOutput("t3_if_valid_count", iValidCount, 1);
    checkOutput("t3_mem_req_cycles", memReqCycles, 6);
    checkOutput("t3_if_rdata", lastIfRdata, 32'hDEADBEEF);

    // Partial store
    resetCounters();
    dQueue.push_back(makeOp(1'b1, 32'h44, 32'h00001234, 4'b0011));
    delayQueue.push_back(3);
    runUntilIdle(40);
    checkOutput("t4_phys_word", physMem[1], 32'hAAAA1234);
    checkOutput("t4_done_count", dDoneCount, 1);

    // Fetch that the memory never answers
    resetCounters();
    iQueue.push_back(32'h300);
    delayQueue.push_back(100);
    runUntilIdle(40);
    checkOutput("t5_mem_req_cycles", memReqCycles, T);
    checkOutput("t5_if_rdata", lastIfRdata, NOP);
    checkOutput("t5_if_valid_count", iValidCount, 1);
    checkOutput("t5_timeout_err", timeout_err, 1);

    // Reset in the middle of a load; the stale response must not complete anything
    resetCounters();
    dQueue.push_back(makeOp(1'b0, 32'h108, 32'h0, 4'hF));
    delayQueue.push_back(100);
    repeat (3) applyStimulus();
    applyReset(1'b1);
    applyStimulus();
    checkOutput("t6_late_ready_no_done", d_done, 0);
    checkOutput("t6_mem_req_idle", mem_req, 0);

    // Randomised traffic against the model
    randomMode = 1;
    repeat (3000) applyStimulus();
    randomMode = 0;
    runUntilIdle(200);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
